// File: rtl/cu_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_fsm : multicycle control-unit FSM for the Otter RV32I core      |
// |          (fetch, execute, load writeback, interrupt entry)         |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module cu_fsm #(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] CU_OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    input  logic       MIE,
    output logic       PC_RST,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       MRET_EXEC,
    output logic       INT_TAKEN
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             pending;
    logic             instr_end;

    assign cnt_done = (cnt == LAT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_INIT;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state <= next_state;
            // Counter only runs while waiting on memory; any state change restarts it.
            if (next_state != state) begin
                cnt <= '0;
            end else if ((state == ST_FETCH || state == ST_WB) && !cnt_done) begin
                cnt <= cnt + 1'b1;
            end
            // Entry into interrupt service wins over a request in the same cycle.
            if (next_state == ST_INTR) begin
                pending <= 1'b0;
            end else if (INTR) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        instr_end  = 1'b0;
        PC_RST     = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        MEM_RDEN1  = 1'b0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        CSR_WE     = 1'b0;
        MRET_EXEC  = 1'b0;
        INT_TAKEN  = 1'b0;

        case (state)
            ST_INIT: begin
                PC_RST     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                if (cnt_done) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_end = 1'b1;
                PC_WRITE  = 1'b1;
                case (CU_OPCODE)
                    OPC_LOAD: begin
                        instr_end  = 1'b0;
                        PC_WRITE   = 1'b0;
                        MEM_RDEN2  = 1'b1;
                        next_state = ST_WB;
                    end
                    OPC_STORE: MEM_WE2 = 1'b1;
                    OPC_BRANCH: ;
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM:
                        REG_WRITE = 1'b1;
                    OPC_SYSTEM: begin
                        if (FUNC3 == 3'b001) begin
                            CSR_WE    = 1'b1;
                            REG_WRITE = 1'b1;
                        end else if (FUNC3 == 3'b000) begin
                            MRET_EXEC = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                MEM_RDEN2 = 1'b1;
                if (cnt_done) begin
                    REG_WRITE = 1'b1;
                    PC_WRITE  = 1'b1;
                    instr_end = 1'b1;
                end
            end
            ST_INTR: begin
                INT_TAKEN  = 1'b1;
                PC_WRITE   = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_INIT;
        endcase

        // Interrupts are only taken on an instruction boundary.
        if (instr_end) begin
            next_state = ((pending | INTR) & MIE) ? ST_INTR : ST_FETCH;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cu_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cu_fsm : self-checking bench for cu_fsm, MEM_LAT=0 and 2        |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_cu_fsm;

    // Output vector: {PC_RST,PC_WRITE,REG_WRITE,RDEN1,RDEN2,WE2,CSR_WE,MRET,INT}
    localparam logic [8:0] V_INIT  = 9'h100;
    localparam logic [8:0] V_FETCH = 9'h020;
    localparam logic [8:0] V_INT   = 9'h081;
    localparam logic [8:0] V_WB    = 9'h010;
    localparam logic [8:0] V_WBEND = 9'h0D0;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0][6:0] opc;
    logic [1:0][2:0] f3;
    logic [1:0]      intr;
    logic [1:0]      mie;
    logic [1:0]      pc_rst, pc_write, reg_write, rden1, rden2, we2, csr_we, mret, int_taken;

    int         checks = 0;
    int         errors = 0;
    bit         pend_m [2];
    logic [8:0] plan_q [$];
    logic [6:0] ops [13] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                             7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011, 7'b1110011,
                             7'b1110011, 7'b1111111, 7'b0001111};

    always #5 clk = ~clk;

    cu_fsm #(.MEM_LAT(0), .CNT_W(4)) dut0 (
        .CLK(clk), .RST_N(rst_n), .CU_OPCODE(opc[0]), .FUNC3(f3[0]), .INTR(intr[0]), .MIE(mie[0]),
        .PC_RST(pc_rst[0]), .PC_WRITE(pc_write[0]), .REG_WRITE(reg_write[0]),
        .MEM_RDEN1(rden1[0]), .MEM_RDEN2(rden2[0]), .MEM_WE2(we2[0]), .CSR_WE(csr_we[0]),
        .MRET_EXEC(mret[0]), .INT_TAKEN(int_taken[0])
    );

    cu_fsm #(.MEM_LAT(2), .CNT_W(4)) dut1 (
        .CLK(clk), .RST_N(rst_n), .CU_OPCODE(opc[1]), .FUNC3(f3[1]), .INTR(intr[1]), .MIE(mie[1]),
        .PC_RST(pc_rst[1]), .PC_WRITE(pc_write[1]), .REG_WRITE(reg_write[1]),
        .MEM_RDEN1(rden1[1]), .MEM_RDEN2(rden2[1]), .MEM_WE2(we2[1]), .CSR_WE(csr_we[1]),
        .MRET_EXEC(mret[1]), .INT_TAKEN(int_taken[1])
    );

    function automatic logic [8:0] obs(input int d);
        return {pc_rst[d], pc_write[d], reg_write[d], rden1[d], rden2[d],
                we2[d], csr_we[d], mret[d], int_taken[d]};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Execute-cycle strobes for an opcode, straight from the instruction-class table.
    function automatic logic [8:0] exec_vec(input logic [6:0] op, input logic [2:0] f);
        case (op)
            7'b0000011: return 9'h010;
            7'b0100011: return 9'h088;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011:
                return 9'h0C0;
            7'b1110011: return (f == 3'b001) ? 9'h0C4 : (f == 3'b000) ? 9'h082 : 9'h080;
            default:    return 9'h080;
        endcase
    endfunction

    // Whole-instruction strobe timeline, excluding any interrupt entry.
    function automatic void build_plan(input int d, input logic [6:0] op, input logic [2:0] f);
        plan_q.delete();
        for (int i = 0; i <= lat_of(d); i++) plan_q.push_back(V_FETCH);
        plan_q.push_back(exec_vec(op, f));
        if (op == LOAD) begin
            for (int i = 0; i < lat_of(d); i++) plan_q.push_back(V_WB);
            plan_q.push_back(V_WBEND);
        end
    endfunction

    // Leaves the DUTs in their post-reset INIT cycle; the next negedge is the first fetch.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        intr  = '0;
        mie   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pend_m[0] = 1'b0;
        pend_m[1] = 1'b0;
    endtask

    task automatic test_reset();
        opc = {OPIMM, OPIMM};
        f3  = '0;
        intr = '0;
        mie  = '0;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== V_INIT) begin
                    errors++;
                    $display("FAIL reset_hold d%0d c%0d: got %h expected %h", d, c, obs(d), V_INIT);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs(0) !== V_INIT) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs(0), V_INIT);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs(0) !== V_FETCH) begin
            errors++;
            $display("FAIL reset_fetch: got %h expected %h", obs(0), V_FETCH);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs(0) !== 9'h0C0 || obs(1) !== V_FETCH) begin
            errors++;
            $display("FAIL reset_exec: got %h/%h expected 0c0/%h", obs(0), obs(1), V_FETCH);
        end
    endtask

    task automatic test_op_imm();
        do_reset();
        opc[0] = OPIMM;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs(0) !== V_FETCH) begin
                errors++;
                $display("FAIL opimm_fetch n%0d: got %h expected %h", n, obs(0), V_FETCH);
            end
            @(negedge clk);
            #1;
            checks++;
            if (obs(0) !== 9'h0C0) begin
                errors++;
                $display("FAIL opimm_exec n%0d: got %h expected 0c0", n, obs(0));
            end
        end
    endtask

    task automatic test_load_lat2();
        logic [8:0] exp_seq [8];
        exp_seq = '{V_FETCH, V_FETCH, V_FETCH, V_WB, V_WB, V_WB, V_WBEND, V_FETCH};
        do_reset();
        opc[1] = LOAD;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs(1) !== exp_seq[c]) begin
                errors++;
                $display("FAIL load_lat2 c%0d: got %h expected %h", c, obs(1), exp_seq[c]);
            end
        end
    endtask

    task automatic test_store_intr();
        logic [8:0] exp_seq [6];
        exp_seq = '{V_FETCH, 9'h088, V_INT, V_FETCH, 9'h0C0, V_FETCH};
        do_reset();
        mie[0] = 1'b1;
        opc[0] = STORE;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            intr[0] = (c == 0);
            if (c == 3) opc[0] = OPIMM;
            #1;
            checks++;
            if (obs(0) !== exp_seq[c]) begin
                errors++;
                $display("FAIL store_intr c%0d: got %h expected %h", c, obs(0), exp_seq[c]);
            end
        end
    endtask

    task automatic test_mie_late();
        logic [8:0] expv;
        do_reset();
        opc[1] = OPIMM;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 4 && k != 4) break;
                @(negedge clk);
                intr[1] = (k == 0 && c == 0);
                if (c == 0) mie[1] = (k >= 4);
                expv = (c < 3) ? V_FETCH : (c == 3) ? 9'h0C0 : V_INT;
                #1;
                checks++;
                if (obs(1) !== expv) begin
                    errors++;
                    $display("FAIL mie_late k%0d c%0d: got %h expected %h", k, c, obs(1), expv);
                end
            end
        end
    endtask

    task automatic test_system();
        logic [2:0] fs   [4];
        logic [6:0] os   [4];
        logic [8:0] expv [4];
        fs   = '{3'b001, 3'b000, 3'b000, 3'b010};
        os   = '{SYSTEM, SYSTEM, 7'b1111111, SYSTEM};
        expv = '{9'h0C4, 9'h082, 9'h080, 9'h080};
        do_reset();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            opc[0] = os[n];
            f3[0]  = fs[n];
            @(negedge clk);
            #1;
            checks++;
            if (obs(0) !== expv[n]) begin
                errors++;
                $display("FAIL system n%0d: got %h expected %h", n, obs(0), expv[n]);
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        do_reset();
        opc[1] = LOAD;
        repeat (7) @(negedge clk);
        #1;
        checks++;
        if (obs(1) !== V_WBEND) begin
            errors++;
            $display("FAIL midwb_pre: got %h expected %h", obs(1), V_WBEND);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs(1) !== V_INIT) begin
            errors++;
            $display("FAIL midwb_async: got %h expected %h", obs(1), V_INIT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs(1) !== V_INIT) begin
            errors++;
            $display("FAIL midwb_init: got %h expected %h", obs(1), V_INIT);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs(1) !== V_FETCH) begin
            errors++;
            $display("FAIL midwb_fetch: got %h expected %h", obs(1), V_FETCH);
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [2:0] fv;
        bit         take;
        for (int d = 0; d < 2; d++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                op = ops[$urandom_range(0, 12)];
                fv = 3'($urandom_range(0, 3));
                build_plan(d, op, fv);
                take = 1'b0;
                for (int i = 0; i < plan_q.size(); i++) begin
                    @(negedge clk);
                    opc[d]  = op;
                    f3[d]   = fv;
                    intr[d] = ($urandom_range(0, 5) == 0);
                    if ($urandom_range(0, 3) == 0) mie[d] = ~mie[d];
                    #1;
                    checks++;
                    if (obs(d) !== plan_q[i]) begin
                        errors++;
                        $display("FAIL random d%0d n%0d i%0d op%b: got %h expected %h",
                                 d, n, i, op, obs(d), plan_q[i]);
                    end
                    if (i == plan_q.size() - 1) begin
                        take = (pend_m[d] | intr[d]) & mie[d];
                        pend_m[d] = take ? 1'b0 : (pend_m[d] | intr[d]);
                    end else begin
                        pend_m[d] = pend_m[d] | intr[d];
                    end
                end
                if (take) begin
                    @(negedge clk);
                    intr[d] = ($urandom_range(0, 5) == 0);
                    if ($urandom_range(0, 3) == 0) mie[d] = ~mie[d];
                    #1;
                    checks++;
                    if (obs(d) !== V_INT) begin
                        errors++;
                        $display("FAIL random_int d%0d n%0d: got %h expected %h", d, n, obs(d), V_INT);
                    end
                    pend_m[d] = pend_m[d] | intr[d];
                end
            end
        end
    endtask

    initial begin
        opc  = '0;
        f3   = '0;
        intr = '0;
        mie  = '0;
        test_reset();
        test_op_imm();
        test_load_lat2();
        test_store_intr();
        test_mie_late();
        test_system();
        test_reset_mid_wb();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
